// File: rtl/tff_seq_pkg.sv
// Shared types and helpers for the T-flip-flop write sequencer.
package tff_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TOGGLE = 2'd1,
    DONE   = 2'd2
  } seq_state_e;

  // Round-robin pointer value after reset: requester 0 has top priority.
  localparam int unsigned RR_INIT = 32'd0;

  // Counts set bits; callers zero-extend narrower vectors to 64 bits.
  function automatic logic [6:0] popcount(input logic [63:0] vec);
    logic [6:0] acc;
    acc = 7'd0;
    for (int i = 0; i < 64; i++) begin
      acc = acc + {6'd0, vec[i]};
    end
    return acc;
  endfunction

endpackage

// File: rtl/tff_write_sequencer_if.sv
// Requester-side handshake bundle: per-requester valid, target data and ready pulse.
interface tff_write_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/tff_cell.sv
// Single T flip-flop: q inverts on every rising edge where t is high.
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);
  logic q_r;

  // Toggle storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= 1'b0;
    end else if (t) begin
      q_r <= ~q_r;
    end
  end

  assign q = q_r;
endmodule

// File: rtl/tff_write_sequencer.sv
// Round-robin write sequencer presenting a T-flip-flop register as a plain writable register.
// Build option TFF_SEQ_PARALLEL_EN: toggle all mismatching bits in one cycle instead of walking bit by bit.
module tff_write_sequencer
  import tff_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  tff_write_sequencer_if.slave req_if,
  output logic [WIDTH-1:0]     q,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic [CW-1:0]        toggle_cnt
);

  localparam logic [GW:0] NREQ_W = (GW + 1)'(NREQ);

  seq_state_e       state_r;
  seq_state_e       state_nxt_s;
  logic [GW-1:0]    ptr_r;
  logic [GW-1:0]    grant_r;
  logic [GW-1:0]    off_s;
  logic [GW-1:0]    pick_s;
  logic [GW-1:0]    ptr_nxt_s;
  logic [2*NREQ-1:0] rot_s;
  logic             any_s;
  logic [WIDTH-1:0] target_r;
  logic [WIDTH-1:0] sel_data_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] t_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic [CW-1:0]    toggle_cnt_r;
  logic             last_s;

  function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] a, input logic [GW-1:0] b);
    logic [GW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    sum = (sum >= NREQ_W) ? (sum - NREQ_W) : sum;
    return sum[GW-1:0];
  endfunction

  // Round-robin pick: rotate valids so the pointer lands at bit 0, take the lowest set bit.
  always_comb begin
    any_s = |req_if.req_valid;
    rot_s = {req_if.req_valid, req_if.req_valid} >> ptr_r;
    off_s = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      off_s = rot_s[j] ? GW'(j) : off_s;
    end
    pick_s    = wrap_add(ptr_r, off_s);
    ptr_nxt_s = wrap_add(pick_s, GW'(1));
  end

  // Target value of the requester being picked.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_data_s = (pick_s == GW'(i)) ? req_if.req_data[i*WIDTH +: WIDTH] : sel_data_s;
    end
  end

  assign diff_s = target_r ^ q;

`ifdef TFF_SEQ_PARALLEL_EN
  // One-shot toggle of every mismatching bit.
  always_comb begin
    t_s       = (state_r == TOGGLE) ? diff_s : '0;
    cnt_nxt_s = CW'(popcount(64'(diff_s)));
    last_s    = 1'b1;
  end
`else
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic [IW-1:0] idx_r;

  // Serial walk: only bit idx may toggle in a given cycle.
  always_comb begin
    t_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t_s[i] = (state_r == TOGGLE) && (idx_r == IW'(i)) && diff_s[i];
    end
    cnt_nxt_s = cnt_r + CW'(|t_s);
    last_s    = (idx_r == IW'(WIDTH - 1));
  end

  // Bit index of the walk, restarted whenever the FSM is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r <= '0;
    end else if (state_r == IDLE) begin
      idx_r <= '0;
    end else if (state_r == TOGGLE) begin
      idx_r <= idx_r + IW'(1);
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = any_s ? TOGGLE : IDLE;
      TOGGLE:  state_nxt_s = last_s ? DONE : TOGGLE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Grant, target latch, running count and published count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r        <= GW'(RR_INIT);
      grant_r      <= '0;
      target_r     <= '0;
      cnt_r        <= '0;
      toggle_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            grant_r  <= pick_s;
            ptr_r    <= ptr_nxt_s;
            target_r <= sel_data_s;
            cnt_r    <= '0;
          end
        end
        TOGGLE:  cnt_r <= cnt_nxt_s;
        DONE:    toggle_cnt_r <= cnt_r;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Status decoded straight from the state so ready lasts exactly the DONE cycle.
  always_comb begin
    busy             = (state_r != IDLE);
    req_if.req_ready = '0;
    if (state_r == DONE) begin
      req_if.req_ready[grant_r] = 1'b1;
    end else begin
      req_if.req_ready = '0;
    end
  end

  assign grant_id   = grant_r;
  assign toggle_cnt = toggle_cnt_r;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (reset),
      .t     (t_s[g]),
      .q     (q[g])
    );
  end

endmodule
